// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port among NUM_MASTERS bus masters.
//
// Each master presents a request (m_read / m_write) with address, write data
// and access width. In IDLE the arbiter picks a winner, either round-robin
// starting after the last served master or fixed priority with index 0
// highest. The winner's operands are latched into the s_* registers. They
// stay constant until the memory answers with s_ok. After the answer, the
// winner receives a one-cycle m_ok pulse. Read data is kept on m_rdata until
// the next completed read.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   m_addr/m_wdata    per-master operands, master i in slice i
//   m_width           per-master access width (0 byte, 1 half, 2 word)
//   m_read/m_write    per-master request strobes (both high => write)
//   m_rdata           read data shared by all masters
//   m_ok              per-master completion pulse (one cycle)
//   grant             one-hot current owner, zero when idle
//   s_*               registered request towards memory
//   s_rdata, s_ok     memory response
module mem_arbiter #(
    parameter int NUM_MASTERS = 3,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int RR_MODE     = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_MASTERS*ADDR_W-1:0] m_addr,
    input  logic [NUM_MASTERS*DATA_W-1:0] m_wdata,
    input  logic [NUM_MASTERS*2-1:0]      m_width,
    input  logic [NUM_MASTERS-1:0]        m_read,
    input  logic [NUM_MASTERS-1:0]        m_write,
    output logic [DATA_W-1:0]             m_rdata,
    output logic [NUM_MASTERS-1:0]        m_ok,
    output logic [NUM_MASTERS-1:0]        grant,
    output logic [ADDR_W-1:0]             s_addr,
    output logic [DATA_W-1:0]             s_wdata,
    output logic [1:0]                    s_width,
    output logic                          s_read,
    output logic                          s_write,
    input  logic [DATA_W-1:0]             s_rdata,
    input  logic                          s_ok
);

    localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

    state_e                   state_q,   state_d;
    logic [NUM_MASTERS-1:0]   grant_q,   grant_d;
    logic [IDX_W-1:0]         win_q,     win_d;
    logic [IDX_W-1:0]         last_q,    last_d;
    logic [ADDR_W-1:0]        s_addr_q,  s_addr_d;
    logic [DATA_W-1:0]        s_wdata_q, s_wdata_d;
    logic [1:0]               s_width_q, s_width_d;
    logic                     s_read_q,  s_read_d;
    logic                     s_write_q, s_write_d;
    logic [DATA_W-1:0]        m_rdata_q, m_rdata_d;

    logic [NUM_MASTERS-1:0]   req;
    logic [IDX_W-1:0]         pick;
    logic [IDX_W-1:0]         cand;
    logic                     found;

    // Winner selection. Round-robin searches from last_q+1 upward with wrap.
    // Fixed priority takes the lowest requesting index.
    always_comb begin
        req   = m_read | m_write;
        pick  = '0;
        cand  = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            if (RR_MODE != 0) begin
                cand = IDX_W'((int'(last_q) + k + 1) % NUM_MASTERS);
            end else begin
                cand = IDX_W'(k);
            end
            if (!found && req[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
    end

    // NOTE: every signal written here gets its hold value first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        win_d     = win_q;
        last_d    = last_q;
        s_addr_d  = s_addr_q;
        s_wdata_d = s_wdata_q;
        s_width_d = s_width_q;
        s_read_d  = s_read_q;
        s_write_d = s_write_q;
        m_rdata_d = m_rdata_q;

        unique case (state_q)
            IDLE: begin
                if (found) begin
                    state_d       = BUSY;
                    win_d         = pick;
                    grant_d       = '0;
                    grant_d[pick] = 1'b1;
                    s_addr_d      = m_addr[int'(pick)*ADDR_W +: ADDR_W];
                    s_wdata_d     = m_wdata[int'(pick)*DATA_W +: DATA_W];
                    s_width_d     = m_width[int'(pick)*2 +: 2];
                    // A master strobing both read and write is served as a write.
                    s_write_d     = m_write[pick];
                    s_read_d      = m_read[pick] & ~m_write[pick];
                end
            end
            BUSY: begin
                if (s_ok) begin
                    state_d   = DONE;
                    s_read_d  = 1'b0;
                    s_write_d = 1'b0;
                    if (s_read_q) begin
                        m_rdata_d = s_rdata;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                grant_d = '0;
                last_d  = win_q;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            win_q     <= '0;
            last_q    <= IDX_W'(NUM_MASTERS - 1);
            s_addr_q  <= '0;
            s_wdata_q <= '0;
            s_width_q <= '0;
            s_read_q  <= 1'b0;
            s_write_q <= 1'b0;
            m_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            win_q     <= win_d;
            last_q    <= last_d;
            s_addr_q  <= s_addr_d;
            s_wdata_q <= s_wdata_d;
            s_width_q <= s_width_d;
            s_read_q  <= s_read_d;
            s_write_q <= s_write_d;
            m_rdata_q <= m_rdata_d;
        end
    end

    assign m_ok    = (state_q == DONE) ? grant_q : '0;
    assign grant   = grant_q;
    assign s_addr  = s_addr_q;
    assign s_wdata = s_wdata_q;
    assign s_width = s_width_q;
    assign s_read  = s_read_q;
    assign s_write = s_write_q;
    assign m_rdata = m_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: self-checking bench for mem_arbiter.
// A round-robin instance is exercised with directed and random traffic.
// It is checked against a transaction-level model: pending requests, the
// last winner and the last read data. A fixed-priority instance checks
// the starvation behaviour of the priority mode.
module tb_mem_arbiter;

    localparam int N  = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = N + AW + DW + 2 + 1 + 1 + N;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // round-robin instance
    logic [N*AW-1:0] m_addr;
    logic [N*DW-1:0] m_wdata;
    logic [N*2-1:0]  m_width;
    logic [N-1:0]    m_read, m_write, m_ok, grant;
    logic [DW-1:0]   m_rdata, s_wdata, s_rdata;
    logic [AW-1:0]   s_addr;
    logic [1:0]      s_width;
    logic            s_read, s_write, s_ok;

    // fixed-priority instance
    logic [N*AW-1:0] f_m_addr;
    logic [N*DW-1:0] f_m_wdata;
    logic [N*2-1:0]  f_m_width;
    logic [N-1:0]    f_m_read, f_m_write, f_m_ok, f_grant;
    logic [DW-1:0]   f_m_rdata, f_s_wdata, f_s_rdata;
    logic [AW-1:0]   f_s_addr;
    logic [1:0]      f_s_width;
    logic            f_s_read, f_s_write, f_s_ok;

    mem_arbiter #(.NUM_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .RR_MODE(1)) dut (
        .clk(clk), .rst(rst),
        .m_addr(m_addr), .m_wdata(m_wdata), .m_width(m_width),
        .m_read(m_read), .m_write(m_write),
        .m_rdata(m_rdata), .m_ok(m_ok), .grant(grant),
        .s_addr(s_addr), .s_wdata(s_wdata), .s_width(s_width),
        .s_read(s_read), .s_write(s_write),
        .s_rdata(s_rdata), .s_ok(s_ok)
    );

    mem_arbiter #(.NUM_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .RR_MODE(0)) dut_fp (
        .clk(clk), .rst(rst),
        .m_addr(f_m_addr), .m_wdata(f_m_wdata), .m_width(f_m_width),
        .m_read(f_m_read), .m_write(f_m_write),
        .m_rdata(f_m_rdata), .m_ok(f_m_ok), .grant(f_grant),
        .s_addr(f_s_addr), .s_wdata(f_s_wdata), .s_width(f_s_width),
        .s_read(f_s_read), .s_write(f_s_write),
        .s_rdata(f_s_rdata), .s_ok(f_s_ok)
    );

    int checks   = 0;
    int failures = 0;

    // transaction-level model
    int            model_last;
    logic [DW-1:0] model_rdata;
    logic [AW-1:0] op_addr  [N];
    logic [DW-1:0] op_wdata [N];
    logic [1:0]    op_width [N];
    logic          op_rd    [N];
    logic          op_wr    [N];

    task automatic set_master(input int i, input logic rd, input logic wr,
                              input logic [AW-1:0] a, input logic [DW-1:0] d,
                              input logic [1:0] w);
        op_rd[i]    = rd;
        op_wr[i]    = wr;
        op_addr[i]  = a;
        op_wdata[i] = d;
        op_width[i] = w;
        m_addr[i*AW +: AW]  = a;
        m_wdata[i*DW +: DW] = d;
        m_width[i*2 +: 2]   = w;
        m_read[i]           = rd;
        m_write[i]          = wr;
    endtask

    task automatic clear_master(input int i);
        set_master(i, 1'b0, 1'b0, '0, '0, 2'd0);
    endtask

    task automatic rand_request(input int i);
        int rw;
        rw = $urandom_range(1, 3);
        set_master(i, rw[0], rw[1], $urandom, $urandom, 2'($urandom_range(0, 2)));
    endtask

    function automatic logic [N-1:0] pending();
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) r[i] = op_rd[i] | op_wr[i];
        return r;
    endfunction

    // Round-robin rule: first requester at or after (last winner + 1), wrapping.
    function automatic int model_pick(input logic [N-1:0] r);
        for (int k = 1; k <= N; k++) begin
            if (r[(model_last + k) % N]) return (model_last + k) % N;
        end
        return -1;
    endfunction

    // One complete transaction on the round-robin instance, started from IDLE.
    // want >= 0 forces the expected winner; otherwise the model decides.
    task automatic do_txn(input int lat, input logic [DW-1:0] rd, input bit noise,
                          input int want, input string tag);
        int              exp;
        logic [N-1:0]    oh;
        logic [BW-1:0]   got, exp_bus;
        logic [2*N+2+DW-1:0] got_d, exp_d;
        exp = (want >= 0) ? want : model_pick(pending());
        if (exp < 0) begin
            checks++;
            failures++;
            $display("FAIL %s: no pending request, got none expected a winner", tag);
            return;
        end
        oh = '0;
        oh[exp] = 1'b1;
        exp_bus = {oh, op_addr[exp], op_wdata[exp], op_width[exp],
                   op_rd[exp] & ~op_wr[exp], op_wr[exp], {N{1'b0}}};

        @(posedge clk); #1;
        got = {grant, s_addr, s_wdata, s_width, s_read, s_write, m_ok};
        checks++;
        if (got !== exp_bus) begin
            failures++;
            $display("FAIL %s busy_entry: got %h expected %h", tag, got, exp_bus);
        end

        for (int c = 0; c < lat; c++) begin
            if (noise) begin
                for (int i = 0; i < N; i++) begin
                    if (i != exp && !(op_rd[i] | op_wr[i]) && $urandom_range(0, 2) == 0)
                        rand_request(i);
                end
                m_addr[exp*AW +: AW]  = $urandom;
                m_wdata[exp*DW +: DW] = $urandom;
                s_rdata               = $urandom;
            end
            @(posedge clk); #1;
            got = {grant, s_addr, s_wdata, s_width, s_read, s_write, m_ok};
            checks++;
            if (got !== exp_bus) begin
                failures++;
                $display("FAIL %s busy_hold: got %h expected %h", tag, got, exp_bus);
            end
        end

        if (op_rd[exp] && !op_wr[exp]) model_rdata = rd;
        s_ok    = 1'b1;
        s_rdata = rd;
        @(posedge clk); #1;
        got_d = {grant, s_read, s_write, m_ok, m_rdata};
        exp_d = {oh, 1'b0, 1'b0, oh, model_rdata};
        checks++;
        if (got_d !== exp_d) begin
            failures++;
            $display("FAIL %s done: got %h expected %h", tag, got_d, exp_d);
        end

        clear_master(exp);
        if (noise) begin
            s_ok    = 1'($urandom_range(0, 1));
            s_rdata = $urandom;
        end else begin
            s_ok = 1'b0;
        end
        @(posedge clk); #1;
        s_ok       = 1'b0;
        model_last = exp;
        got_d = {grant, s_read, s_write, m_ok, m_rdata};
        exp_d = {{N{1'b0}}, 1'b0, 1'b0, {N{1'b0}}, model_rdata};
        checks++;
        if (got_d !== exp_d) begin
            failures++;
            $display("FAIL %s idle: got %h expected %h", tag, got_d, exp_d);
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < N; i++) rand_request(i);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({grant, m_ok, s_read, s_write, s_addr, s_wdata, s_width, m_rdata, f_grant} !== '0) begin
            failures++;
            $display("FAIL reset: got grant=%b m_ok=%b s_rd=%b s_wr=%b s_addr=%h s_wdata=%h s_width=%h m_rdata=%h f_grant=%b expected all zero",
                     grant, m_ok, s_read, s_write, s_addr, s_wdata, s_width, m_rdata, f_grant);
        end
        for (int i = 0; i < N; i++) clear_master(i);
        rst         = 1'b0;
        model_last  = N - 1;
        model_rdata = '0;
    endtask

    task automatic test_idle();
        s_ok = 1'b1;
        for (int c = 0; c < 3; c++) begin
            s_rdata = $urandom;
            @(posedge clk); #1;
            checks++;
            if ({grant, m_ok, s_read, s_write, m_rdata} !== {{2*N+2{1'b0}}, model_rdata}) begin
                failures++;
                $display("FAIL idle_ignore: got grant=%b m_ok=%b m_rdata=%h expected 0 0 %h",
                         grant, m_ok, m_rdata, model_rdata);
            end
        end
        s_ok = 1'b0;
    endtask

    task automatic test_fairness();
        for (int t = 0; t < 6; t++) begin
            for (int i = 0; i < N; i++) begin
                if (!(op_rd[i] | op_wr[i])) set_master(i, 1'b1, 1'b0, $urandom, $urandom, 2'd2);
            end
            do_txn(0, $urandom, 1'b0, t % 3, "fairness");
        end
        for (int i = 0; i < N; i++) clear_master(i);
    endtask

    task automatic test_single_read();
        set_master(1, 1'b1, 1'b0, 32'h0300_0010, '0, 2'd2);
        do_txn(2, 32'hDEADBEEF, 1'b0, -1, "single_read");
        checks++;
        if (m_rdata !== 32'hDEADBEEF || m_ok !== 3'b000) begin
            failures++;
            $display("FAIL single_read_after: got m_rdata=%h m_ok=%b expected deadbeef 000", m_rdata, m_ok);
        end
    endtask

    task automatic test_operand_stability();
        logic [DW-1:0] rd;
        rd = $urandom;
        set_master(0, 1'b1, 1'b0, 32'h100, '0, 2'd2);
        @(posedge clk); #1;
        checks++;
        if (grant !== 3'b001 || s_addr !== 32'h100) begin
            failures++;
            $display("FAIL stability_entry: got grant=%b s_addr=%h expected 001 100", grant, s_addr);
        end
        m_addr[0 +: AW] = 32'h200;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            checks++;
            if (s_addr !== 32'h100 || s_read !== 1'b1) begin
                failures++;
                $display("FAIL stability_hold: got s_addr=%h s_read=%b expected 100 1", s_addr, s_read);
            end
        end
        s_ok    = 1'b1;
        s_rdata = rd;
        @(posedge clk); #1;
        s_ok        = 1'b0;
        model_rdata = rd;
        checks++;
        if (m_ok !== 3'b001 || m_rdata !== rd) begin
            failures++;
            $display("FAIL stability_done: got m_ok=%b m_rdata=%h expected 001 %h", m_ok, m_rdata, rd);
        end
        clear_master(0);
        @(posedge clk); #1;
        model_last = 0;
        checks++;
        if (grant !== 3'b000) begin
            failures++;
            $display("FAIL stability_idle: got grant=%b expected 000", grant);
        end
    endtask

    task automatic test_rw_conflict();
        set_master(1, 1'b1, 1'b1, $urandom, 32'h55, 2'd0);
        do_txn(1, $urandom, 1'b0, 1, "rw_conflict");
    endtask

    task automatic test_reset_mid_busy();
        set_master(2, 1'b0, 1'b1, $urandom, $urandom, 2'd2);
        @(posedge clk); #1;
        checks++;
        if (grant !== 3'b100 || s_write !== 1'b1) begin
            failures++;
            $display("FAIL abort_entry: got grant=%b s_write=%b expected 100 1", grant, s_write);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_last  = N - 1;
        model_rdata = '0;
        checks++;
        if ({grant, m_ok, s_write, s_read, m_rdata} !== '0) begin
            failures++;
            $display("FAIL abort: got grant=%b m_ok=%b s_write=%b s_read=%b m_rdata=%h expected zeros",
                     grant, m_ok, s_write, s_read, m_rdata);
        end
        set_master(0, 1'b1, 1'b0, $urandom, $urandom, 2'd1);
        do_txn(1, $urandom, 1'b0, 0, "after_reset_first");
        do_txn(0, $urandom, 1'b0, -1, "after_reset_second");
    endtask

    task automatic test_fixed();
        logic [DW-1:0] rd;
        for (int t = 0; t < 4; t++) begin
            f_m_read = 3'b101;
            @(posedge clk); #1;
            checks++;
            if (f_grant !== 3'b001 || f_s_read !== 1'b1) begin
                failures++;
                $display("FAIL fixed_grant: got grant=%b s_read=%b expected 001 1", f_grant, f_s_read);
            end
            rd        = $urandom;
            f_s_ok    = 1'b1;
            f_s_rdata = rd;
            @(posedge clk); #1;
            f_s_ok = 1'b0;
            checks++;
            if (f_m_ok !== 3'b001 || f_m_rdata !== rd) begin
                failures++;
                $display("FAIL fixed_done: got m_ok=%b m_rdata=%h expected 001 %h", f_m_ok, f_m_rdata, rd);
            end
            f_m_read[0] = 1'b0;
            @(posedge clk); #1;
            checks++;
            if (f_grant !== 3'b000) begin
                failures++;
                $display("FAIL fixed_idle: got grant=%b expected 000", f_grant);
            end
        end
        @(posedge clk); #1;
        checks++;
        if (f_grant !== 3'b100) begin
            failures++;
            $display("FAIL fixed_low_prio: got grant=%b expected 100", f_grant);
        end
        f_s_ok = 1'b1;
        @(posedge clk); #1;
        f_s_ok   = 1'b0;
        f_m_read = '0;
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < N; i++) begin
                if (!(op_rd[i] | op_wr[i]) && $urandom_range(0, 1) == 1) rand_request(i);
            end
            if (pending() == '0) rand_request($urandom_range(0, N - 1));
            do_txn($urandom_range(0, 3), $urandom, 1'b1, -1, "random");
        end
        for (int i = 0; i < N; i++) clear_master(i);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        m_addr = '0; m_wdata = '0; m_width = '0; m_read = '0; m_write = '0;
        s_ok = 1'b0; s_rdata = '0;
        f_m_addr = '0; f_m_wdata = '0; f_m_width = '0; f_m_read = '0; f_m_write = '0;
        f_s_ok = 1'b0; f_s_rdata = '0;
        for (int i = 0; i < N; i++) begin
            op_rd[i] = 1'b0; op_wr[i] = 1'b0;
            op_addr[i] = '0; op_wdata[i] = '0; op_width[i] = '0;
        end
        model_last  = N - 1;
        model_rdata = '0;
        @(posedge clk); #1;

        test_reset();
        test_idle();
        test_fairness();
        test_single_read();
        test_operand_stability();
        test_rw_conflict();
        test_reset_mid_busy();
        test_fixed();
        test_reset();
        test_random();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
